// File: rtl/hdv_arb_pkg.sv
// hdv_arb_pkg: shared types, defaults and index-width helper for engine-side arbiters
package hdv_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF = 32;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hdv_rr_pick.sv
// hdv_rr_pick: combinational rotate-priority picker, first request above ptr wins
module hdv_rr_pick
  import hdv_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          any_req
);
  always_comb begin
    win = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      win = req[IW'(j)] ? IW'(j) : win;
    end
    any_req = |req;
  end
endmodule

// File: rtl/hdv_stream_arbiter.sv
// hdv_stream_arbiter: packet-locked round-robin AXI-Stream arbiter; HDV_ARB_STALL_WDOG_EN adds a stall watchdog
module hdv_stream_arbiter
  import hdv_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW = DW_DEF,
  parameter int WDOG_W = 16,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [N_REQ*DW-1:0] s_tdata,
  input  logic [N_REQ-1:0] s_tvalid,
  input  logic [N_REQ-1:0] s_tlast,
  output logic [N_REQ-1:0] s_tready,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [IW-1:0]    grant_id,
  output logic             busy,
  output logic             stall_flag
);
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
  logic [DW-1:0] m_data_q, m_data_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic any_req, ready, accept, drain, arb;
  hdv_rr_pick #(.N(N_REQ)) u_pick (
    .req(s_tvalid),
    .ptr(ptr_q),
    .win(win),
    .any_req(any_req)
  );
  always_comb begin
    ready = (state_q == LOCKED) & (~m_valid_q | m_tready);
    s_tready = ready ? (N_REQ'(1) << grant_q) : '0;
    accept = ready & s_tvalid[grant_q];
    drain = m_valid_q & m_tready;
    arb = (state_q == IDLE) & any_req;
    state_d = (state_q == IDLE) ? (any_req ? LOCKED : IDLE)
                                : ((accept & s_tlast[grant_q]) ? IDLE : LOCKED);
    grant_d = arb ? win : grant_q;
    ptr_d = arb ? win : ptr_q;
    m_valid_d = accept | (m_valid_q & ~m_tready);
    m_data_d = accept ? s_tdata[grant_q*DW +: DW] : m_data_q;
    m_last_d = accept ? s_tlast[grant_q] : m_last_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      ptr_q <= IW'(N_REQ - 1);
      grant_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
    end
  end
  assign m_tdata = m_data_q;
  assign m_tvalid = m_valid_q;
  assign m_tlast = m_last_q;
  assign grant_id = grant_q;
  assign busy = (state_q == LOCKED);
`ifdef HDV_ARB_STALL_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic stall_q, stall_d, stuck;
  always_comb begin
    stuck = (m_valid_q & ~m_tready) | ((state_q == LOCKED) & ~accept);
    wdog_d = (accept | drain) ? '0 : ((stuck & ~&wdog_q) ? wdog_q + 1'b1 : wdog_q);
    stall_d = stall_q | &wdog_d;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wdog_q <= '0;
      stall_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      stall_q <= stall_d;
    end
  end
  assign stall_flag = stall_q;
`else
  assign stall_flag = (WDOG_W < 0);
`endif
endmodule

// File: tb/tb_hdv_stream_arbiter.sv
// tb_hdv_stream_arbiter: randomized and directed checks of hdv_stream_arbiter against a packet-level model
module tb_hdv_stream_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
`ifdef HDV_ARB_STALL_WDOG_EN
  localparam logic STALL_EXP = 1'b1;
`else
  localparam logic STALL_EXP = 1'b0;
`endif
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b1;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tlast, m_tready;
  logic [1:0] grant_id;
  logic busy, stall_flag;
  int tests = 0;
  int fails = 0;
  logic [DW:0] q [N][$];
  logic [DW:0] outlog [$];
  int grant_log [$];
  logic ev, el;
  logic [DW-1:0] ed;
  int owner, rrptr;
  bit arb_pend;

  hdv_stream_arbiter #(.N_REQ(N), .DW(DW), .WDOG_W(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .stall_flag(stall_flag)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic int rr(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return last;
  endfunction

  function automatic bit work_left();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return ev || !arb_pend;
  endfunction

  task automatic do_reset();
    ap_rst_n = 1'b0;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    outlog.delete();
    grant_log.delete();
    ev = 1'b0; el = 1'b0; ed = '0;
    owner = 0; rrptr = N - 1; arb_pend = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] vmask, input logic rdy);
    logic [N-1:0] er, acc;
    @(negedge ap_clk);
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = vmask[i] && q[i].size() > 0;
      s_tdata[i*DW +: DW] = (q[i].size() > 0) ? q[i][0][DW-1:0] : '0;
      s_tlast[i] = q[i].size() > 0 && q[i][0][DW];
    end
    m_tready = rdy;
    #1;
    er = '0;
    if (!arb_pend && (!ev || rdy)) er[owner] = 1'b1;
    tests++;
    if (s_tready !== er) begin fails++; $display("FAIL s_tready got %b exp %b t=%0t", s_tready, er, $time); end
    tests++;
    if (busy !== !arb_pend) begin fails++; $display("FAIL busy got %b exp %b t=%0t", busy, !arb_pend, $time); end
    tests++;
    if (grant_id !== 2'(owner)) begin fails++; $display("FAIL grant_id got %0d exp %0d t=%0t", grant_id, owner, $time); end
    tests++;
    if (m_tvalid !== ev) begin fails++; $display("FAIL m_tvalid got %b exp %b t=%0t", m_tvalid, ev, $time); end
    if (ev) begin
      tests++;
      if ({m_tlast, m_tdata} !== {el, ed})
        begin fails++; $display("FAIL m_beat got %b/%h exp %b/%h t=%0t", m_tlast, m_tdata, el, ed, $time); end
    end
    acc = er & s_tvalid;
    if (ev && rdy) outlog.push_back({el, ed});
    if (arb_pend && |s_tvalid) begin
      owner = rr(rrptr, s_tvalid);
      rrptr = owner;
      arb_pend = 1'b0;
      grant_log.push_back(owner);
    end
    if (|acc) begin
      {el, ed} = q[owner].pop_front();
      ev = 1'b1;
      if (el) arb_pend = 1'b1;
    end else if (ev && rdy) ev = 1'b0;
  endtask

  task automatic run(input bit rnd, input int budget);
    int n = 0;
    while (work_left() && n < budget) begin
      step(rnd ? N'($urandom_range(0, 2**N - 1)) : '1, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    tests++;
    if (n >= budget) begin fails++; $display("FAIL run_timeout got %0d cycles exp <%0d", n, budget); end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({m_tvalid, m_tlast, m_tdata, s_tready, grant_id, busy, stall_flag} !== '0)
      begin fails++; $display("FAIL reset_vals got v%b l%b d%h r%b g%0d b%b s%b exp all 0", m_tvalid, m_tlast, m_tdata, s_tready, grant_id, busy, stall_flag); end
    repeat (3) step('1, 1'b1);
  endtask

  task automatic test_single();
    do_reset();
    q[0].push_back({1'b0, 32'hA1});
    q[0].push_back({1'b0, 32'hA2});
    q[0].push_back({1'b1, 32'hA3});
    run(1'b0, 50);
    tests++;
    if (outlog.size() != 3) begin fails++; $display("FAIL single_count got %0d exp 3", outlog.size()); end
    else for (int k = 0; k < 3; k++) begin
      tests++;
      if (outlog[k] !== {k == 2, 32'hA1 + 32'(k)})
        begin fails++; $display("FAIL single_beat%0d got %h exp %h", k, outlog[k], {k == 2, 32'hA1 + 32'(k)}); end
    end
    tests++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin fails++; $display("FAIL single_grant got %p exp '{0}", grant_log); end
  endtask

  task automatic test_contention();
    int exp5 [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++) q[i].push_back({b == 1, 32'hC000 + 32'(i*16 + p*4 + b)});
    run(1'b0, 100);
    tests++;
    if (grant_log.size() != 8) begin fails++; $display("FAIL contention_count got %0d exp 8", grant_log.size()); end
    else for (int k = 0; k < 5; k++) begin
      tests++;
      if (grant_log[k] != exp5[k]) begin fails++; $display("FAIL contention_order%0d got %0d exp %0d", k, grant_log[k], exp5[k]); end
    end
  endtask

  task automatic test_lock();
    int gap = 0;
    int n = 0;
    do_reset();
    for (int b = 0; b < 4; b++) q[1].push_back({b == 3, 32'h100 + 32'(b)});
    for (int b = 0; b < 2; b++) q[2].push_back({b == 1, 32'h200 + 32'(b)});
    while (work_left() && n < 100) begin
      if (q[1].size() == 2 && gap < 3) begin step(4'b1101, 1'b1); gap++; end
      else step('1, 1'b1);
      n++;
    end
    tests++;
    if (outlog.size() != 6) begin fails++; $display("FAIL lock_count got %0d exp 6", outlog.size()); end
    else for (int k = 0; k < 4; k++) begin
      tests++;
      if (outlog[k] !== {k == 3, 32'h100 + 32'(k)})
        begin fails++; $display("FAIL lock_beat%0d got %h exp %h", k, outlog[k], {k == 3, 32'h100 + 32'(k)}); end
    end
    tests++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 2)
      begin fails++; $display("FAIL lock_grants got %p exp '{1,2}", grant_log); end
  endtask

  task automatic test_backpressure();
    logic [DW:0] held;
    do_reset();
    for (int b = 0; b < 3; b++) q[0].push_back({b == 2, 32'hB0 + 32'(b)});
    repeat (2) step('1, 1'b1);
    step('1, 1'b0);
    held = {m_tlast, m_tdata};
    tests++;
    if (held !== {1'b0, 32'hB0}) begin fails++; $display("FAIL bp_first got %h exp %h", held, {1'b0, 32'hB0}); end
    repeat (5) begin
      step('1, 1'b0);
      tests++;
      if ({m_tlast, m_tdata} !== held) begin fails++; $display("FAIL bp_stable got %h exp %h", {m_tlast, m_tdata}, held); end
      tests++;
      if (s_tready !== '0) begin fails++; $display("FAIL bp_ready got %b exp 0", s_tready); end
    end
    run(1'b0, 50);
    tests++;
    if (outlog.size() != 3) begin fails++; $display("FAIL bp_count got %0d exp 3", outlog.size()); end
    else for (int k = 0; k < 3; k++) begin
      tests++;
      if (outlog[k] !== {k == 2, 32'hB0 + 32'(k)})
        begin fails++; $display("FAIL bp_beat%0d got %h exp %h", k, outlog[k], {k == 2, 32'hB0 + 32'(k)}); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    for (int b = 0; b < 4; b++) q[0].push_back({b == 3, 32'hD0 + 32'(b)});
    while (q[0].size() > 2 && n < 20) begin step('1, 1'b1); n++; end
    #1 ap_rst_n = 1'b0;
    #1;
    tests++;
    if ({m_tvalid, m_tlast, m_tdata, s_tready, grant_id, busy, stall_flag} !== '0)
      begin fails++; $display("FAIL midreset_vals got v%b l%b d%h r%b g%0d b%b exp all 0", m_tvalid, m_tlast, m_tdata, s_tready, grant_id, busy); end
    do_reset();
    q[3].push_back({1'b1, 32'hE3});
    q[0].push_back({1'b1, 32'hE0});
    run(1'b0, 50);
    tests++;
    if (outlog.size() != 2 || outlog[0] !== {1'b1, 32'hE0} || grant_log[0] != 0)
      begin fails++; $display("FAIL midreset_prio got %p exp first beat E0 from req0", outlog); end
  endtask

  task automatic test_random();
    int total = 0;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 6; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) q[i].push_back({b == len - 1, 32'($urandom)});
        total += len;
      end
    run(1'b1, 4000);
    tests++;
    if (outlog.size() != total) begin fails++; $display("FAIL random_count got %0d exp %0d", outlog.size(), total); end
  endtask

  task automatic test_watchdog();
    do_reset();
    q[0].push_back({1'b1, 32'h55});
    repeat (10) step('1, 1'b0);
    tests++;
    if (stall_flag !== 1'b0) begin fails++; $display("FAIL wdog_early got %b exp 0", stall_flag); end
    repeat (10) step('1, 1'b0);
    tests++;
    if (stall_flag !== STALL_EXP) begin fails++; $display("FAIL wdog_set got %b exp %b", stall_flag, STALL_EXP); end
    repeat (4) step('1, 1'b1);
    tests++;
    if (stall_flag !== STALL_EXP) begin fails++; $display("FAIL wdog_sticky got %b exp %b", stall_flag, STALL_EXP); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hdv_stream_arbiter.md
Name: hdv_stream_arbiter

Overview:
- Round-robin, packet-locked AXI-Stream arbiter that shares the single sdata_i input of hdv_engine between N_REQ upstream producers (encoder channels, host DMA, test injector).
- Grant is held from the first beat to the TLAST beat, so packets never interleave.
- A one-beat registered output slice decouples engine backpressure from the arbitration logic.
- Sits directly in front of hdv_engine's sdata_i port.

Parameters:
- N_REQ, 4, number of requesting streams (2..16)
- DW, 32, TDATA width in bits
- WDOG_W, 16, stall watchdog counter width (used only with the optional feature)

Ports:
- ap_clk  in  1  single clock; all logic on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- s_tdata  in  N_REQ*DW  requester data; requester i occupies bits [i*DW +: DW]
- s_tvalid  in  N_REQ  per-requester valid
- s_tlast  in  N_REQ  per-requester end-of-packet
- s_tready  out  N_REQ  per-requester ready
- m_tdata  out  DW  data to hdv_engine sdata_i
- m_tvalid  out  1  output valid
- m_tlast  out  1  output end-of-packet
- m_tready  in  1  ready from hdv_engine
- grant_id  out  $clog2(N_REQ)  index of the currently or last granted requester
- busy  out  1  high while in LOCKED
- stall_flag  out  1  watchdog alarm (only with HDV_ARB_STALL_WDOG_EN; otherwise tied 0)

Behaviour:
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, grant_id=0, busy=0, stall_flag=0. The round-robin pointer resets to N_REQ-1, so requester 0 has first priority. State resets to IDLE.
- FSM states: IDLE and LOCKED.
- IDLE:
  - s_tready=0.
  - If any s_tvalid is high, pick the first set bit searching upward from pointer+1 (wrapping modulo N_REQ).
  - Register grant_id, set the pointer to the winner and go to LOCKED on the next edge.
  - If no s_tvalid is high, stay in IDLE.
- LOCKED:
  - s_tready[grant_id] = (~m_tvalid | m_tready). All other s_tready bits are 0.
  - Accept: s_tvalid[g] & s_tready[g]. On accept, load the output register with the beat's data and last, and set m_tvalid=1.
  - Output register: if m_tvalid & m_tready and there is no accept in the same cycle, clear m_tvalid. A simultaneous drain and accept replaces the register contents (full throughput, 1 beat per cycle).
  - If the accepted beat has s_tlast=1, return to IDLE on the next edge. The output register still drains normally.
- Latency: 1 cycle from s-side accept to m_tvalid. There is one arbitration bubble cycle between packets.
- Backpressure: while m_tready=0 and m_tvalid=1, m_tdata and m_tlast hold stable and s_tready is all 0.
- A requester dropping s_tvalid mid-packet keeps the lock; the grant is never pre-empted until TLAST.
- Invalid or duplicate requests from non-granted requesters are ignored; they do not affect the pointer.
- A mid-packet reset returns immediately to reset values. The partial packet is discarded and the engine sees no TLAST.
- grant_id holds its last value while in IDLE.

Optional Feature:
- Macro: HDV_ARB_STALL_WDOG_EN.
- With the macro defined:
  - A WDOG_W-bit counter increments each cycle that m_tvalid=1 and m_tready=0, or that busy=1 with no accept.
  - The counter clears on any accept or output drain.
  - stall_flag is set when the counter saturates at all-ones, is sticky, and clears only on reset. It feeds the kernel deadlock diagnosis.
- Without the macro: no counter is built and stall_flag is constant 0.

Decomposition:
- Shared package hdv_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}
  - function for grant index width
  - default constants N_REQ_DEF and DW_DEF
- Sub-module hdv_rr_pick:
  - Combinational rotate-priority picker.
  - Inputs: req vector, pointer. Outputs: winner index and any_req flag.
  - Reused by other engine-side arbiters.

Test Plan:
- Single requester: req0 sends a 3-beat packet 0xA1, 0xA2, 0xA3 (last), m_tready=1 → grant_id=0, beats appear on m_tdata 1 cycle after each accept, m_tlast only on 0xA3, busy drops after the last accept.
- Contention: req0..req3 all valid with 2-beat packets → grant order 0, 1, 2, 3, 0, with one bubble cycle between packets.
- Lock: req1 holds 4-beat packet and deasserts s_tvalid for 3 cycles mid-packet while req2 is valid → no req2 beat appears before req1's TLAST.
- Backpressure: m_tready=0 for 5 cycles with m_tvalid=1 → m_tdata and m_tlast stable and s_tready=0 throughout; beats resume with no loss or duplication when m_tready=1.
- Reset mid-packet: assert ap_rst_n=0 on beat 2 of 4 → all outputs take reset values asynchronously; after release, requester 0 has priority.
- Watchdog (macro on, WDOG_W=4): m_tready=0 with m_tvalid=1 for 15 cycles → stall_flag=1 and stays 1 after m_tready returns high. With the macro off, stall_flag stays 0.
